esl_clk_check_scheduler: RTL and testbench

//  Time-multiplexes one clock-check core across NUM_CUT clocks-under-test (CUT).

---
 rtl/esl_clk_check_scheduler_if.sv | 21 ++
 rtl/esl_clk_check_scheduler.sv | 151 +++++++++++++++
 tb/tb_esl_clk_check_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/esl_clk_check_scheduler_if.sv
// Scheduler <-> clock-check core link: CUT mux select, core reset and verdict return path.
interface esl_clk_check_scheduler_if #(
  parameter int unsigned SEL_W = 2
);
  logic             core_rst_n;
  logic [SEL_W-1:0] cut_sel;
  logic             core_verdict;
  logic             core_cut_stopped;
  logic             core_freq_err;
  logic [2:0]       core_state;

  modport master (
    output core_rst_n, cut_sel,
    input  core_verdict, core_cut_stopped, core_freq_err, core_state
  );

  modport slave (
    input  core_rst_n, cut_sel,
    output core_verdict, core_cut_stopped, core_freq_err, core_state
  );
endinterface

// File: rtl/esl_clk_check_scheduler.sv
// Round-robin scheduler sharing one clock-check core across NUM_CUT clocks-under-test,
// with settle/reset sequencing, a verdict watchdog and sticky per-channel status.
module esl_clk_check_scheduler #(
  parameter int unsigned NUM_CUT        = 4,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       ref_clk,
  input  logic                       ref_rst_n,
  input  logic                       sched_en,
  input  logic [NUM_CUT-1:0]         chan_mask,
  input  logic [NUM_CUT-1:0]         fail_clr,
  esl_clk_check_scheduler_if.master  core,
  output logic                       busy,
  output logic [NUM_CUT-1:0]         chan_fail,
  output logic [NUM_CUT-1:0]         chan_tmo,
  output logic                       round_done,
  output logic                       sched_error
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0]  CORE_ERR = 3'b101;

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, RUN, RECORD, ERROR} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] top;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             fail;

  // Next enabled channel after ptr (or from channel 0 inclusive on the first pick after reset).
  always_comb begin
    int unsigned start;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    start = first ? 0 : 32'(ptr) + 1;
    for (int unsigned i = 0; i < NUM_CUT; i++) begin
      idx = (start + i) % NUM_CUT;
      if (!found && chan_mask[SEL_W'(idx)]) begin
        pick  = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < NUM_CUT; i++) begin
      if (chan_mask[i]) top = SEL_W'(i);
    end
  end

  always_ff @(posedge ref_clk or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      first           <= 1'b1;
      fail            <= 1'b0;
      core.core_rst_n <= 1'b0;
      core.cut_sel    <= '0;
      busy            <= 1'b0;
      chan_fail       <= '0;
      chan_tmo        <= '0;
      round_done      <= 1'b0;
      sched_error     <= 1'b0;
    end else begin
      round_done <= 1'b0;
      // Clear first; a bit set later in this block overrides, so a same-cycle set wins.
      chan_fail  <= chan_fail & ~fail_clr;
      chan_tmo   <= chan_tmo & ~fail_clr;
      if (state != IDLE && state != ERROR && core.core_rst_n && core.core_state == CORE_ERR) begin
        state           <= ERROR;
        core.core_rst_n <= 1'b0;
        busy            <= 1'b0;
        sched_error     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            core.core_rst_n <= 1'b0;
            if (sched_en && |chan_mask) begin
              state <= SELECT;
              busy  <= 1'b1;
            end
          end
          SELECT: begin
            if (|chan_mask) begin
              ptr          <= pick;
              core.cut_sel <= pick;
              first        <= 1'b0;
              cnt          <= '0;
              state        <= SETTLE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
              core.core_rst_n <= 1'b1;
              cnt             <= '0;
              state           <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            cnt <= cnt + 1'b1;
            if (core.core_verdict) begin
              fail  <= core.core_cut_stopped | core.core_freq_err;
              state <= RECORD;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              fail          <= 1'b1;
              chan_tmo[ptr] <= 1'b1;
              state         <= RECORD;
            end
          end
          RECORD: begin
            core.core_rst_n <= 1'b0;
            if (fail) chan_fail[ptr] <= 1'b1;
            if (ptr == top && chan_mask[ptr]) round_done <= 1'b1;
            if (sched_en && |chan_mask) begin
              state <= SELECT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          ERROR: begin
            core.core_rst_n <= 1'b0;
            sched_error     <= 1'b1;
            busy            <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esl_clk_check_scheduler.sv
// Directed bench for esl_clk_check_scheduler: vector table for the rotation plus hand-written corner sequences.
module tb_esl_clk_check_scheduler;

  logic       ref_clk = 1'b0;
  logic       ref_rst_n = 1'b0;
  logic       sched_en = 1'b0;
  logic [3:0] chan_mask = '0;
  logic [3:0] fail_clr = '0;
  logic       busy, round_done, sched_error;
  logic [3:0] chan_fail, chan_tmo;

  int total = 0;
  int bad   = 0;

  esl_clk_check_scheduler_if #(.SEL_W(2)) core ();

  esl_clk_check_scheduler #(
    .NUM_CUT(4), .SEL_W(2), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .ref_clk(ref_clk), .ref_rst_n(ref_rst_n), .sched_en(sched_en),
    .chan_mask(chan_mask), .fail_clr(fail_clr), .core(core.master),
    .busy(busy), .chan_fail(chan_fail), .chan_tmo(chan_tmo),
    .round_done(round_done), .sched_error(sched_error)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic [1:0] sel;
    logic       timeout;
    logic       stopped;
    logic       freq;
    logic [3:0] clr;
    logic [3:0] fail;
    logic [3:0] tmo;
    logic       rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_run();
    int n = 0;
    while (core.core_rst_n !== 1'b1 && n < 300) begin
      @(negedge ref_clk);
      n++;
    end
    if (core.core_rst_n !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_run: core_rst_n never released within %0d cycles", n);
    end
  endtask

  task automatic apply(input vec_t v);
    wait_run();
    chk("cut_sel", 32'(core.cut_sel), 32'(v.sel));
    chk("busy_run", 32'(busy), 1);
    if (!v.timeout) begin
      repeat (2) @(negedge ref_clk);
      core.core_verdict     = 1'b1;
      core.core_cut_stopped = v.stopped;
      core.core_freq_err    = v.freq;
      @(negedge ref_clk);
      core.core_verdict     = 1'b0;
      core.core_cut_stopped = 1'b0;
      core.core_freq_err    = 1'b0;
      fail_clr              = v.clr;
      @(negedge ref_clk);
      fail_clr = '0;
    end else begin
      repeat (63) @(negedge ref_clk);
      chk("tmo_not_yet", 32'(chan_tmo[v.sel]), 0);
      @(negedge ref_clk);
      chk("tmo_at_limit", 32'(chan_tmo[v.sel]), 1);
      fail_clr = v.clr;
      @(negedge ref_clk);
      fail_clr = '0;
    end
    chk("chan_fail", 32'(chan_fail), 32'(v.fail));
    chk("chan_tmo", 32'(chan_tmo), 32'(v.tmo));
    chk("round_done", 32'(round_done), 32'(v.rd));
    chk("core_rst_low", 32'(core.core_rst_n), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    core.core_verdict     = 1'b0;
    core.core_cut_stopped = 1'b0;
    core.core_freq_err    = 1'b0;
    core.core_state       = 3'b000;

    //          sel   tmo   stop  freq  clr      fail     tmo      rd
    vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{2'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[2] = '{2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[4] = '{2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[5] = '{2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b1000, 1'b1};
    vecs[6] = '{2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1011, 4'b1000, 1'b0};
    vecs[7] = '{2'd1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b1011, 4'b1000, 1'b0};
    vecs[8] = '{2'd3, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0010, 4'b0000, 1'b1};

    repeat (3) @(negedge ref_clk);
    chk("rst_core_rst_n", 32'(core.core_rst_n), 0);
    chk("rst_cut_sel", 32'(core.cut_sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fail", 32'(chan_fail), 0);
    chk("rst_tmo", 32'(chan_tmo), 0);
    chk("rst_round_done", 32'(round_done), 0);
    chk("rst_sched_error", 32'(sched_error), 0);
    ref_rst_n = 1'b1;
    @(negedge ref_clk);

    // Start latency: IDLE -> core_rst_n high
    chan_mask = 4'b1011;
    sched_en  = 1'b1;
    n = 0;
    while (core.core_rst_n !== 1'b1 && n < 50) begin
      @(negedge ref_clk);
      n++;
    end
    chk("start_latency", 32'(n), 10);

    for (int i = 0; i < 9; i++) apply(vecs[i]);

    // Write-1-to-clear of a lone sticky fail
    fail_clr = 4'b0010;
    @(negedge ref_clk);
    fail_clr = '0;
    chk("fail_clr", 32'(chan_fail), 0);

    // sched_en drop mid-RUN on ch1
    apply('{2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    wait_run();
    sched_en = 1'b0;
    apply('{2'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0});
    chk("idle_busy", 32'(busy), 0);
    core.core_verdict  = 1'b1;
    core.core_freq_err = 1'b1;
    @(negedge ref_clk);
    core.core_verdict  = 1'b0;
    core.core_freq_err = 1'b0;
    chan_mask = 4'b0000;
    sched_en  = 1'b1;
    repeat (20) @(negedge ref_clk);
    chk("mask0_busy", 32'(busy), 0);
    chk("stray_verdict_fail", 32'(chan_fail), 32'(4'b0010));

    // Reset mid-SETTLE, ptr was 1 so next pick is ch3
    chan_mask = 4'b1011;
    repeat (5) @(negedge ref_clk);
    chk("settle_sel", 32'(core.cut_sel), 3);
    #2 ref_rst_n = 1'b0;
    #1;
    chk("arst_cut_sel", 32'(core.cut_sel), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fail", 32'(chan_fail), 0);
    chk("arst_core_rst_n", 32'(core.core_rst_n), 0);
    @(negedge ref_clk);
    ref_rst_n = 1'b1;

    // Restart picks ch0; mask shrunk to ch2 mid-RUN does not abort
    wait_run();
    chan_mask = 4'b0100;
    apply('{2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    apply('{2'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1});

    // Single channel: same select still goes through SELECT + SETTLE
    n = 1;
    while (core.core_rst_n !== 1'b1 && n < 50) begin
      @(negedge ref_clk);
      if (core.core_rst_n !== 1'b1) n++;
    end
    chk("single_settle_len", 32'(n), 9);
    chk("single_sel", 32'(core.cut_sel), 2);

    // Core internal error during RUN
    core.core_state = 3'b101;
    @(negedge ref_clk);
    chk("err_flag", 32'(sched_error), 1);
    chk("err_core_rst_n", 32'(core.core_rst_n), 0);
    chk("err_busy", 32'(busy), 0);
    core.core_state = 3'b000;
    repeat (5) @(negedge ref_clk);
    chk("err_hold", 32'(sched_error), 1);
    chk("err_hold_busy", 32'(busy), 0);
    #2 ref_rst_n = 1'b0;
    #1;
    chk("err_cleared", 32'(sched_error), 0);
    @(negedge ref_clk);
    ref_rst_n = 1'b1;
    @(negedge ref_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
